// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

  localparam int DEMUX_DATA_W = 8;
  localparam int DEMUX_N_CH   = 4;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Saturating increment for the out-of-range beat counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/stream_demux_n_out_reg.sv
// One-entry valid/data holding register for a single demux output channel.
module demux_out_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // A load only arrives while the slot is free, so it may overwrite a beat
  // that is draining on the same edge without losing anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign free  = !valid_reg || ready;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N valid/ready stream demultiplexer with broadcast mode and
// out-of-range select detection.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int N_CH   = DEMUX_N_CH,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   err_sel,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam logic [SEL_W:0] N_CH_LIM = (SEL_W + 1)'(N_CH);

  logic [N_CH-1:0] ch_hit;
  logic [N_CH-1:0] ch_free;
  logic [N_CH-1:0] ch_load;
  logic            sel_in_range;
  logic            sel_free;
  logic            accept;
  logic            discard;

  logic                 err_sel_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  // Always true when N_CH is a power of two.
  assign sel_in_range = ({1'b0, in_sel} < N_CH_LIM);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_hit[gi]  = sel_in_range && (in_sel == SEL_W'(gi));
      assign ch_load[gi] = accept && (in_bcast || ch_hit[gi]);

      demux_out_reg #(
        .DATA_W(DATA_W)
      ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ch_load[gi]),
        .load_data(in_data),
        .ready    (out_ready[gi]),
        .valid    (out_valid[gi]),
        .data     (out_data[gi*DATA_W +: DATA_W]),
        .free     (ch_free[gi])
      );
    end
  endgenerate

  // in_ready never looks at in_valid, keeping the handshake free of loops.
  always_comb begin
    sel_free = |(ch_free & ch_hit);
    if (rst) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &ch_free;
    end else if (sel_in_range) begin
      in_ready = sel_free;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept  = in_valid && in_ready;
  assign discard = accept && !in_bcast && !sel_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      err_sel_reg <= discard;
      if (discard) begin
        err_cnt_reg <= sat_inc(err_cnt_reg);
      end
    end
  end

  assign err_sel = err_sel_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n: a 4-channel instance for routing,
// backpressure, broadcast and reset, and a 3-channel instance for bad selects.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-channel instance
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [7:0]  in_data4 = '0;
  logic [1:0]  in_sel4 = '0;
  logic        in_bcast4 = 1'b0;
  logic [3:0]  out_valid4;
  logic [3:0]  out_ready4 = 4'b1111;
  logic [31:0] out_data4;
  logic        err_sel4;
  logic [7:0]  err_cnt4;

  // 3-channel instance
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [7:0]  in_data3 = '0;
  logic [1:0]  in_sel3 = '0;
  logic        in_bcast3 = 1'b0;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = 3'b111;
  logic [23:0] out_data3;
  logic        err_sel3;
  logic [7:0]  err_cnt3;

  stream_demux_n #(.DATA_W(8), .N_CH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_sel(in_sel4), .in_bcast(in_bcast4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .err_sel(err_sel4), .err_cnt(err_cnt4)
  );

  stream_demux_n #(.DATA_W(8), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_sel(in_sel3), .in_bcast(in_bcast3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .err_sel(err_sel3), .err_cnt(err_cnt3)
  );

  logic [7:0] exp_q [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every held beat must match the head of its channel queue; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid4[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL ch%0d_unexpected actual=valid data 0x%0h required=no beat", i, out_data4[i*8 +: 8]);
          end else if (out_data4[i*8 +: 8] !== exp_q[i][0]) begin
            errors++;
            $display("FAIL ch%0d_data actual=0x%0h required=0x%0h", i, out_data4[i*8 +: 8], exp_q[i][0]);
            if (out_ready4[i]) void'(exp_q[i].pop_front());
          end else begin
            $display("mon  ch%0d beat 0x%0h%s", i, exp_q[i][0], out_ready4[i] ? " taken" : " held");
            if (out_ready4[i]) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  // One cycle on dut4: drive at posedge+1, check at negedge, record accepted beat.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] s, input logic b,
                      input logic exp_rdy, input logic [3:0] exp_ov);
    in_valid4 = v; in_data4 = d; in_sel4 = s; in_bcast4 = b;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready4}, {31'b0, exp_rdy});
    chk("out_valid", {28'b0, out_valid4}, {28'b0, exp_ov});
    if (v && exp_rdy) begin
      if (b) begin
        for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
      end else begin
        exp_q[s].push_back(d);
      end
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {28'b0, out_valid4}, 32'h0);
    chk("rst_out_data", out_data4, 32'h0);
    chk("rst_err_cnt", {24'b0, err_cnt4}, 32'h0);
    chk("rst_err_sel", {31'b0, err_sel4}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready4}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Unicast to each channel, all consumers ready
    step(1, 8'hA1, 2'd0, 0, 1, 4'b0000);
    step(1, 8'hB2, 2'd1, 0, 1, 4'b0001);
    step(1, 8'hC3, 2'd2, 0, 1, 4'b0010);
    step(1, 8'hD4, 2'd3, 0, 1, 4'b0100);
    step(0, 8'h00, 2'd0, 0, 1, 4'b1000);
    step(0, 8'h00, 2'd0, 0, 1, 4'b0000);

    // Backpressure on channel 2
    out_ready4 = 4'b1011;
    step(1, 8'h55, 2'd2, 0, 1, 4'b0000);
    step(1, 8'h66, 2'd2, 0, 0, 4'b0100);
    step(1, 8'h11, 2'd1, 0, 1, 4'b0100);
    out_ready4 = 4'b1111;
    step(1, 8'h66, 2'd2, 0, 1, 4'b0110);
    chk("ch2_after_release", {24'b0, out_data4[23:16]}, 32'h66);
    step(0, 8'h00, 2'd0, 0, 1, 4'b0100);
    step(0, 8'h00, 2'd0, 0, 1, 4'b0000);

    // Broadcast stalls behind full channel 2, then lands on all channels
    out_ready4 = 4'b1011;
    step(1, 8'h33, 2'd2, 0, 1, 4'b0000);
    step(1, 8'h77, 2'd0, 1, 0, 4'b0100);
    step(1, 8'h77, 2'd0, 1, 0, 4'b0100);
    out_ready4 = 4'b1111;
    step(1, 8'h77, 2'd0, 1, 1, 4'b0100);
    step(0, 8'h00, 2'd0, 0, 1, 4'b1111);
    chk("bcast_data", out_data4, 32'h77777777);
    step(0, 8'h00, 2'd0, 0, 1, 4'b0000);

    // Same-cycle drain and load on channel 0
    out_ready4 = 4'b1110;
    step(1, 8'h0F, 2'd0, 0, 1, 4'b0000);
    out_ready4 = 4'b1111;
    step(1, 8'h10, 2'd0, 0, 1, 4'b0001);
    step(0, 8'h00, 2'd1, 0, 1, 4'b0001);
    step(0, 8'h00, 2'd1, 0, 1, 4'b0000);

    // Out-of-range select on the 3-channel instance
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h99;
    @(negedge clk);
    chk("oor_in_ready", {31'b0, in_ready3}, 32'h1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("oor_err_sel_pulse", {31'b0, err_sel3}, 32'h1);
    chk("oor_err_cnt", {24'b0, err_cnt3}, 32'h1);
    chk("oor_out_valid", {29'b0, out_valid3}, 32'h0);
    @(posedge clk); #1;
    in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h5A;
    @(negedge clk);
    chk("oor_err_sel_drop", {31'b0, err_sel3}, 32'h0);
    chk("n3_in_ready", {31'b0, in_ready3}, 32'h1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("n3_out_valid", {29'b0, out_valid3}, 32'h4);
    chk("n3_ch2_data", {24'b0, out_data3[23:16]}, 32'h5A);
    chk("n3_err_sel", {31'b0, err_sel3}, 32'h0);
    @(posedge clk); #1;
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h99;
    repeat (300) @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    @(negedge clk);
    chk("oor_err_cnt_sat", {24'b0, err_cnt3}, 32'hFF);
    chk("oor_err_sel_last", {31'b0, err_sel3}, 32'h1);
    @(posedge clk); #1;

    // Reset mid-operation with beats held in channels 0 and 3
    out_ready4 = 4'b0000;
    step(1, 8'hE0, 2'd0, 0, 1, 4'b0000);
    step(1, 8'hE3, 2'd3, 0, 1, 4'b0001);
    step(0, 8'h00, 2'd0, 0, 0, 4'b1001);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", {28'b0, out_valid4}, 32'h0);
    chk("mid_rst_out_data", out_data4, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready4}, 32'h0);
    chk("mid_rst_err_cnt", {24'b0, err_cnt3}, 32'h0);
    @(posedge clk); #1;
    out_ready4 = 4'b1111;
    rst = 1'b0;
    step(1, 8'h42, 2'd3, 0, 1, 4'b0000);
    step(0, 8'h00, 2'd0, 0, 1, 4'b1000);
    step(0, 8'h00, 2'd0, 0, 1, 4'b0000);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ch%0d_queue_left", i), exp_q[i].size(), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes. It is the successor to the fixed 1:4 combinational demux. It routes each accepted input beat to one selected output channel, or to all channels in broadcast mode, through a one-entry register per channel. It also detects out-of-range selects and counts them. It sits between a single producer and N independent consumers in the datapath.

## Interface
- DATA_W, 8, payload width in bits
- N_CH, 4, number of output channels (2..16; need not be a power of two)
- SEL_W, $clog2(N_CH), select width (derived; not overridden)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept the beat this cycle
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  target channel index
- in_bcast  in  1  1 = deliver the beat to every channel, and in_sel is ignored
- out_valid  out  N_CH  per-channel beat present, bit i = channel i
- out_ready  in  N_CH  per-channel consumer ready
- out_data  out  N_CH*DATA_W  channel i payload at [i*DATA_W +: DATA_W]
- err_sel  out  1  one-cycle pulse when an out-of-range beat is accepted
- err_cnt  out  8  count of out-of-range beats, saturating

## Operation
- Each channel i has a one-entry holding register, v[i] plus d[i]. out_valid[i] = v[i] and out_data slice i = d[i].
- Channel i is free when !v[i] or out_ready[i].
- in_ready rules:
  - Broadcast (in_bcast=1): in_ready = AND of free over all channels.
  - Otherwise, with in_sel < N_CH: in_ready = free[in_sel].
  - Otherwise, with in_sel >= N_CH: in_ready = 1.
- An input beat is accepted when in_valid & in_ready.
- On an accepted unicast beat: v[in_sel] <= 1 and d[in_sel] <= in_data.
- On an accepted broadcast beat: every v[i] <= 1 and every d[i] <= in_data.
- On an accepted beat with in_sel >= N_CH (non-broadcast):
  - The beat is discarded.
  - err_sel = 1 next cycle, for one cycle.
  - err_cnt increments and holds at 255.
- Out-of-range selects are only possible when N_CH is not a power of two.
- Channel drain: when v[i] & out_ready[i] and no new beat is loaded into channel i, v[i] <= 0.
- Simultaneous drain and load on one channel: the load wins. v[i] stays 1 and d[i] takes the new data, so a channel sustains one beat per cycle.
- in_data and in_sel are don't-care when in_valid=0. No state changes.
- Non-selected channels are untouched by a unicast beat, and their drain proceeds independently.
- No beat is ever dropped, duplicated or reordered within a channel. The only exception is the out-of-range discard.

## Timing
- Reset values: all out_valid = 0, all out_data = 0, err_sel = 0, err_cnt = 0.
- During rst=1, in_ready = 0.
- Reset asserted mid-transfer clears all held beats at that edge, with no drain.
- Latency: a beat accepted at edge k appears on out_valid and out_data after edge k; it is visible in cycle k+1.
- in_ready is combinational from out_ready, in_sel, in_bcast and the v[] state. It has no combinational path from in_valid.
- out_valid and out_data are registered outputs.
- Once out_valid[i] is asserted, it and its data stay stable until out_ready[i]=1 at a clock edge.
- Throughput: 1 beat/cycle on a unicast stream to a continuously ready channel. Broadcast achieves 1 beat/cycle only if all channels are ready.
- err_sel is registered. It is high exactly in the cycle after the discarding edge.
- err_cnt updates on the same edge that err_sel rises.

## Structure
- Package stream_demux_pkg holds:
  - the default constants DEMUX_DATA_W = 8 and DEMUX_N_CH = 4;
  - the err_cnt width ERR_CNT_W = 8 and its saturation value.
- Sub-module demux_out_reg is a one-entry valid/data register with load, ready and free outputs. It is generated N_CH times.
- The top level holds:
  - the select decode;
  - the in_ready reduction;
  - the error pulse and counter.

## Test plan
- Setup: N_CH=4, DATA_W=8, all out_ready=1, unicast beats.
  - Send 0xA1/sel 0, 0xB2/sel 1, 0xC3/sel 2, 0xD4/sel 3 on consecutive cycles. Each appears only on its channel one cycle after acceptance.
  - in_ready stays 1 throughout, and no other out_valid bit rises.
- Backpressure on one channel:
  - out_ready[2]=0 with channel 2 holding 0x55. A new beat to sel 2 gives in_ready=0 and 0x55 holds stable.
  - A beat to sel 1 is still accepted.
  - Raise out_ready[2]; on that same edge 0x66 loads, and the next cycle shows 0x66.
- Broadcast:
  - out_ready=4'b1011 with channel 2 full. A bcast 0x77 stalls (in_ready=0).
  - After channel 2 drains, 0x77 appears on all four channels in the same cycle.
- Out-of-range select with N_CH=3:
  - sel=3, data 0x99, accepted. No out_valid rises, err_sel pulses for one cycle, err_cnt = 1.
  - After 300 such beats, err_cnt = 255.
- Reset mid-operation:
  - Assert rst with channels 0 and 3 holding beats and out_ready=0.
  - The next cycle shows out_valid = 0000, out_data = 0, err_cnt = 0, and in_ready = 0 while rst is high.
- Same-cycle drain and load:
  - Channel 0 is full and out_ready[0]=1; a new beat 0x10 to sel 0 arrives.
  - out_valid[0] stays 1 across the edge, and data switches to 0x10 with no bubble.
